// File: rtl/bus_region_pkg.sv
// Shared types and default memory map for the bus region controller.
// The default map places ROM at 0x00, RAM at 0x40 and the LED port at 0x80.
package bus_region_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] FAULT_WORD_DEF = 32'hC01D_C0FE;

    localparam logic [31:0] ROM_BASE = 32'h00;
    localparam logic [31:0] ROM_SIZE = 32'h40;
    localparam logic [3:0]  ROM_WAIT = 4'd0;
    localparam logic [31:0] RAM_BASE = 32'h40;
    localparam logic [31:0] RAM_SIZE = 32'h40;
    localparam logic [3:0]  RAM_WAIT = 4'd1;
    localparam logic [31:0] LED_BASE = 32'h80;
    localparam logic [31:0] LED_SIZE = 32'h04;
    localparam logic [3:0]  LED_WAIT = 4'd2;

    localparam logic [95:0] DEF_REGION_BASE = {LED_BASE, RAM_BASE, ROM_BASE};
    localparam logic [95:0] DEF_REGION_SIZE = {LED_SIZE, RAM_SIZE, ROM_SIZE};
    localparam logic [11:0] DEF_REGION_WAIT = {LED_WAIT, RAM_WAIT, ROM_WAIT};

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/region_match.sv
// Address decoder: compares an address against every region and picks the
// lowest-indexed hit.
module region_match
    import bus_region_pkg::*;
#(
    parameter int                          ADDR_W      = 32,
    parameter int                          N_REGIONS   = 3,
    parameter int                          IDX_W       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE
) (
    input  logic [ADDR_W-1:0]    addr,
    output logic                 hit,
    output logic [N_REGIONS-1:0] sel,
    output logic [IDX_W-1:0]     idx
);

    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   limit;

    // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
    always_comb begin
        hit   = 1'b0;
        sel   = '0;
        idx   = '0;
        base  = '0;
        limit = '0;
        // Scan from the top so the lowest matching index is the one left standing.
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            base  = REGION_BASE[i*ADDR_W +: ADDR_W];
            limit = {1'b0, base} + {1'b0, REGION_SIZE[i*ADDR_W +: ADDR_W]};
            if (addr >= base && {1'b0, addr} < limit) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_region_controller.sv
// Address-latching region decoder with per-region wait states, ready
// handshake, sticky fault flag and optional burst auto-increment.
module bus_region_controller
    import bus_region_pkg::*;
#(
    parameter int                          ADDR_W      = 32,
    parameter int                          DATA_W      = 32,
    parameter int                          N_REGIONS   = 3,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE = DEF_REGION_SIZE,
    parameter logic [N_REGIONS*4-1:0]      REGION_WAIT = DEF_REGION_WAIT,
    parameter logic [DATA_W-1:0]           FAULT_WORD  = FAULT_WORD_DEF,
    parameter bit                          AUTO_INC    = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 rd,
    input  logic                 wr,
    inout  wire  [DATA_W-1:0]    bus,
    output logic                 ready,
    output logic                 fault,
    output logic [N_REGIONS-1:0] rd_sel,
    output logic [N_REGIONS-1:0] wr_sel,
    output logic [ADDR_W-1:0]    word_addr
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    state_t                 state, state_n;
    logic [ADDR_W-1:0]      addr;
    logic [3:0]             cnt;
    logic [N_REGIONS-1:0]   sel_q;
    logic                   valid_q;
    logic                   rd_q;

    logic                   m_hit;
    logic [N_REGIONS-1:0]   m_sel;
    logic [IDX_W-1:0]       m_idx;
    logic [3:0]             wait_sel;
    logic                   req_valid;
    logic                   accept;

    region_match #(
        .ADDR_W      (ADDR_W),
        .N_REGIONS   (N_REGIONS),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_SIZE (REGION_SIZE)
    ) u_match (
        .addr (addr),
        .hit  (m_hit),
        .sel  (m_sel),
        .idx  (m_idx)
    );

    assign wait_sel  = REGION_WAIT[m_idx*4 +: 4];
    assign req_valid = m_hit && (addr[1:0] == 2'b00) && !(rd && wr);
    assign accept    = (state == IDLE) && !load && (rd || wr);
    assign word_addr = m_hit ? ((addr - REGION_BASE[m_idx*ADDR_W +: ADDR_W]) >> WORD_SHIFT) : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_n = (!req_valid || wait_sel == 4'd0) ? RESP : WAIT;
            end
            WAIT: begin
                if (load || (!rd && !wr))
                    state_n = IDLE;
                else if (cnt == 4'd0)
                    state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            cnt     <= '0;
            fault   <= 1'b0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state <= state_n;

            if (load) begin
                addr  <= ADDR_W'(bus);
                fault <= 1'b0;
            end else begin
                if (state == RESP && AUTO_INC)
                    addr <= addr + ADDR_W'(4);
                if (accept && !req_valid)
                    fault <= 1'b1;
            end

            if (accept) begin
                sel_q   <= req_valid ? m_sel : '0;
                valid_q <= req_valid;
                rd_q    <= rd;
                cnt     <= (wait_sel != 4'd0) ? wait_sel - 4'd1 : 4'd0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // A load landing in RESP cancels the completion, so the strobes are gated by it.
    assign ready  = (state == RESP) && !load;
    assign rd_sel = ((state == WAIT || state == RESP) && rd_q) ? sel_q : '0;
    assign wr_sel = (state == RESP && !load && !rd_q) ? sel_q : '0;

    assign bus = (state == RESP && !valid_q && rd_q) ? FAULT_WORD : 'z;

endmodule

// File: tb/tb_bus_region_controller.sv
// Directed bench for bus_region_controller using the default three-region map,
// with simple ROM/RAM slaves modelled on the shared bus.
module tb_bus_region_controller;
    import bus_region_pkg::*;

    localparam logic [31:0] ROM_DATA = 32'h1234_5678;
    localparam logic [31:0] RAM_DATA = 32'hAAAA_5555;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        rd;
    logic        wr;
    logic        tb_en;
    logic [31:0] tb_val;
    wire  [31:0] bus;
    logic        ready;
    logic        fault;
    logic [2:0]  rd_sel;
    logic [2:0]  wr_sel;
    logic [31:0] word_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign bus = tb_en ? tb_val : (rd_sel[0] ? ROM_DATA : (rd_sel[1] ? RAM_DATA : 'z));

    bus_region_controller dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .rd        (rd),
        .wr        (wr),
        .bus       (bus),
        .ready     (ready),
        .fault     (fault),
        .rd_sel    (rd_sel),
        .wr_sel    (wr_sel),
        .word_addr (word_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a);
        tb_en  = 1'b1;
        tb_val = a;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        tb_en  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; rd = 1'b0; wr = 1'b0; tb_en = 1'b0; tb_val = '0;
        tick(); tick();
        check("rst_ready",  {31'd0, ready}, 32'd0);
        check("rst_fault",  {31'd0, fault}, 32'd0);
        check("rst_rd_sel", {29'd0, rd_sel}, 32'd0);
        check("rst_wr_sel", {29'd0, wr_sel}, 32'd0);
        check("rst_addr",   dut.addr, 32'h0);
        rst = 1'b0;
        tick();

        // 1: ROM read, zero wait states
        do_load(32'h00);
        rd = 1'b1;
        tick();
        check("rom_ready",  {31'd0, ready}, 32'd1);
        check("rom_rd_sel", {29'd0, rd_sel}, 32'b001);
        check("rom_bus",    bus, ROM_DATA);
        check("rom_waddr",  word_addr, 32'h0);
        rd = 1'b0;
        tick();
        check("rom_ready_off", {31'd0, ready}, 32'd0);
        check("rom_inc",       dut.addr, 32'h04);
        check("rom_waddr_inc", word_addr, 32'h1);

        // 2: RAM write, one wait state
        do_load(32'h48);
        check("ram_waddr", word_addr, 32'h2);
        wr = 1'b1;
        tick();
        check("ram_wait_ready",  {31'd0, ready}, 32'd0);
        check("ram_wait_wr_sel", {29'd0, wr_sel}, 32'b000);
        tick();
        check("ram_ready",  {31'd0, ready}, 32'd1);
        check("ram_wr_sel", {29'd0, wr_sel}, 32'b010);
        wr = 1'b0;
        tick();
        check("ram_wr_sel_off", {29'd0, wr_sel}, 32'b000);
        check("ram_inc_waddr",  word_addr, 32'h3);

        // 3: unmapped read, plus the exclusive upper edge of the LED region
        do_load(32'h84);
        check("led_edge_waddr", word_addr, 32'h0);
        do_load(32'h100);
        rd = 1'b1;
        tick();
        check("unm_ready",  {31'd0, ready}, 32'd1);
        check("unm_fault",  {31'd0, fault}, 32'd1);
        check("unm_bus",    bus, 32'hC01D_C0FE);
        check("unm_rd_sel", {29'd0, rd_sel}, 32'b000);
        rd = 1'b0;
        tick();
        check("unm_fault_sticky", {31'd0, fault}, 32'd1);
        check("unm_inc",          dut.addr, 32'h104);
        do_load(32'h00);
        check("load_clears_fault", {31'd0, fault}, 32'd0);

        // 4: misaligned read, then rd+wr conflict on an aligned RAM address
        do_load(32'h42);
        rd = 1'b1;
        tick();
        check("mis_fault",  {31'd0, fault}, 32'd1);
        check("mis_ready",  {31'd0, ready}, 32'd1);
        check("mis_rd_sel", {29'd0, rd_sel}, 32'b000);
        rd = 1'b0;
        tick();
        do_load(32'h40);
        rd = 1'b1; wr = 1'b1;
        tick();
        check("cfl_fault",  {31'd0, fault}, 32'd1);
        check("cfl_rd_sel", {29'd0, rd_sel}, 32'b000);
        check("cfl_wr_sel", {29'd0, wr_sel}, 32'b000);
        rd = 1'b0; wr = 1'b0;
        tick();

        // 5: burst read crossing from ROM into RAM
        do_load(32'h3C);
        rd = 1'b1;
        tick();
        check("bst1_ready",  {31'd0, ready}, 32'd1);
        check("bst1_waddr",  word_addr, 32'hF);
        check("bst1_rd_sel", {29'd0, rd_sel}, 32'b001);
        tick();
        check("bst_idle_ready", {31'd0, ready}, 32'd0);
        check("bst2_waddr",     word_addr, 32'h0);
        tick();
        check("bst2_wait_rd_sel", {29'd0, rd_sel}, 32'b010);
        check("bst2_wait_ready",  {31'd0, ready}, 32'd0);
        tick();
        check("bst2_ready", {31'd0, ready}, 32'd1);
        check("bst2_bus",   bus, RAM_DATA);
        rd = 1'b0;
        tick();
        check("bst2_inc_waddr", word_addr, 32'h1);

        // 6a: LED write aborted by load during WAIT
        do_load(32'h80);
        wr = 1'b1;
        tick();
        check("abt_state_wait", {30'd0, dut.state}, {30'd0, WAIT});
        check("abt_wait_wr_sel", {29'd0, wr_sel}, 32'b000);
        tb_en = 1'b1; tb_val = 32'h40; load = 1'b1;
        tick();
        load = 1'b0; tb_en = 1'b0; wr = 1'b0;
        check("abt_state_idle", {30'd0, dut.state}, {30'd0, IDLE});
        check("abt_addr",       dut.addr, 32'h40);
        check("abt_wr_sel",     {29'd0, wr_sel}, 32'b000);
        tick();
        check("abt_no_ready", {31'd0, ready}, 32'd0);
        check("abt_no_wr",    {29'd0, wr_sel}, 32'b000);

        // 6b: fault set, then LED read interrupted by asynchronous reset
        do_load(32'h7C);
        rd = 1'b1; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        check("led_addr", dut.addr, 32'h80);
        tick();
        check("led_wait_rd_sel", {29'd0, rd_sel}, 32'b100);
        check("led_fault_held",  {31'd0, fault}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_sel", {29'd0, rd_sel}, 32'b000);
        check("arst_fault",  {31'd0, fault}, 32'd0);
        check("arst_ready",  {31'd0, ready}, 32'd0);
        check("arst_state",  {30'd0, dut.state}, {30'd0, IDLE});
        check("arst_addr",   dut.addr, 32'h0);
        rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_region_controller.md
Name: bus_region_controller

Overview:
Parametrised successor to the fixed three-region memory controller. Latches an address from the shared tri-state bus and decodes it against N configurable regions. Adds per-region wait states, a ready handshake, fault signalling for unmapped, misaligned or conflicting accesses, and optional address auto-increment for back-to-back bursts. Sits between the CPU bus master and ROM, RAM and peripheral slaves, driving their select lines and word addresses.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, bus data width in bits.
N_REGIONS, 3, number of decoded regions.
REGION_BASE, {32'h80, 32'h40, 32'h00}, packed array of per-region byte base addresses (index 0 = LSBs).
REGION_SIZE, {32'h04, 32'h40, 32'h40}, packed array of per-region byte sizes.
REGION_WAIT, {4'd2, 4'd1, 4'd0}, packed array of per-region wait-state counts (0-15).
FAULT_WORD, 32'hC01D_C0FE, value driven on a faulted read.
AUTO_INC, 1, when 1, address advances by 4 after each completed access.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
load  input  1  latch bus into address register
rd  input  1  read request, held until ready
wr  input  1  write request, held until ready
bus  inout  DATA_W  shared address/data bus
ready  output  1  one-cycle completion strobe
fault  output  1  sticky error flag
rd_sel  output  N_REGIONS  per-region read enable
wr_sel  output  N_REGIONS  per-region write strobe
word_addr  output  ADDR_W  (addr - REGION_BASE[sel]) >> 2; 0 when unmapped

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high. Under reset: addr=0, state=IDLE, wait counter=0, ready=0, fault=0, rd_sel=0, wr_sel=0, bus released (Z).
- Region match:
  - Hit when REGION_BASE[i] <= addr < REGION_BASE[i]+REGION_SIZE[i].
  - Sum computed in ADDR_W+1 bits, so no wrap.
  - Lowest index wins on overlap.
  - Region select is latched at request acceptance.
- Request is invalid (faulted) when: no region hits, addr[1:0] != 0, or rd and wr are both high.
- State machine IDLE / WAIT / RESP:
  - IDLE: at a posedge with (rd|wr) and !load, accept the request. Go to RESP if it is invalid or REGION_WAIT=0; otherwise go to WAIT with cnt=REGION_WAIT-1.
  - WAIT: if cnt=0, go to RESP; else cnt decrements. If rd and wr both drop, abort to IDLE: no strobe, no increment, no fault.
  - RESP: ready=1 for exactly one cycle, then go to IDLE. Latency from the accepting edge to ready = REGION_WAIT+1 cycles.
- Selects:
  - rd_sel[i] is high throughout WAIT and RESP for a valid read.
  - wr_sel[i] pulses only in RESP for a valid write, so each write commits once.
  - No select is asserted for invalid requests.
- Bus drive:
  - The block drives FAULT_WORD only in RESP of an invalid read; otherwise Z.
  - A slave drives the bus only while its rd_sel is high.
- fault:
  - Set on entering RESP for an invalid request.
  - Cleared only by load or rst.
  - ready still pulses on an invalid request, so the master never hangs.
- Auto-increment: if AUTO_INC=1, addr <= addr+4 (mod 2^ADDR_W) at the RESP edge. Applies to faulted accesses too.
- Back-to-back: rd/wr still high in the IDLE cycle after RESP starts a new access at the new address.
- load:
  - Highest priority in every state. Sets addr <= bus and clears fault.
  - In WAIT or RESP it aborts the access: go to IDLE, no wr_sel pulse, no increment.

Decomposition:
- Package bus_region_pkg: state enum (IDLE, WAIT, RESP), FAULT_WORD default, default map constants (ROM/RAM/LED base, size, wait), word-shift constant 2.
- Sub-module region_match: combinational comparators plus priority encoder. Outputs hit, one-hot sel, and index.

Test Plan:
1. Reset/ROM read: reset, load 0x00, hold rd, ROM drives 0x1234_5678 -> rd_sel=001, ready 1 cycle after acceptance, bus=0x1234_5678, then addr=0x04.
2. RAM write: load 0x48, hold wr -> word_addr=2, ready at +2 cycles, wr_sel=010 for exactly one cycle.
3. Unmapped read: load 0x100, hold rd -> ready at +1, bus=0xC01D_C0FE, fault=1, no selects; a later load clears fault.
4. Misaligned and rd+wr conflict: load 0x42 with rd -> fault=1, no rd_sel. Load 0x40 with rd and wr both high -> fault=1, no selects.
5. Burst: load 0x3C, rd held for two accesses -> first hits ROM (word_addr=0xF), second at 0x40 hits RAM (word_addr=0) with 1 wait state.
6. Abort: LED write at 0x80 with wait=2; assert load with bus=0x40 in WAIT -> no wr_sel pulse, addr=0x40, state=IDLE. Assert rst mid-WAIT -> all outputs 0 asynchronously.
